// File: rtl/program_loader_if.sv
// ---------------------------------------------------------------------------
// program_loader_if
// Groups the byte-stream handshake, the instruction-memory write port and the
// loader status lines into one bundle.
//   master : the side that supplies start/rx_* and observes everything else
//   slave  : the program_loader itself
// Signals:
//   start       single-cycle request to begin a load
//   rx_data     incoming program byte
//   rx_valid    rx_data valid
//   rx_ready    loader accepts a byte this cycle
//   imem_we     instruction-memory write enable
//   imem_waddr  instruction-memory byte write address
//   imem_wdata  instruction word to write
//   cpu_reset   active-low processor reset (low holds the core)
//   busy        load in progress
//   done        program loaded, core released
//   error       bad header, core held
// ---------------------------------------------------------------------------
interface program_loader_if;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, busy, done, error
  );

  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, busy, done, error
  );
endinterface

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Receives a program image over a byte stream (16-bit little-endian word
// count N followed by 4N little-endian instruction bytes), writes each word
// into instruction memory starting at BASE_ADDR, and releases the processor
// reset once the whole image is in place. A zero or oversized count holds the
// core in reset and flags error.
// Ports:
//   clock  sole clock, rising edge
//   reset  asynchronous active-low reset
//   bus    program_loader_if slave (handshake, imem write port, status)
// Parameters:
//   DEPTH      instruction-memory capacity in 32-bit words (1..65535)
//   BASE_ADDR  byte address of the first loaded word (word aligned)
// ---------------------------------------------------------------------------
module program_loader #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic            clock,
  input  logic            reset,
  program_loader_if.slave bus
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_n;
  logic [1:0]  r_byte_idx;
  logic [15:0] r_word_idx;
  logic [31:0] r_word;
  logic [31:0] r_waddr;
  logic [31:0] r_wdata;

  logic        w_rx_ready;
  logic        w_hs;
  logic [15:0] w_n_full;
  logic        w_hdr_bad;
  logic        w_last_word;
  logic [31:0] w_word_next;

  // rx_ready depends on registered state only, so the handshake never
  // creates an input-to-output path.
  assign w_rx_ready  = (r_state == HDR0) || (r_state == HDR1) || (r_state == DATA);
  assign w_hs        = bus.rx_valid && w_rx_ready;
  assign w_n_full    = {bus.rx_data, r_n[7:0]};
  assign w_hdr_bad   = (w_n_full == 16'd0) || ({1'b0, w_n_full} > DEPTH_L);
  assign w_last_word = (r_word_idx == (r_n - 16'd1));

  // Byte lane steering: the incoming byte replaces the lane selected by
  // byte_idx, all other lanes keep the partially assembled word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_word_next[8*gi +: 8] = (r_byte_idx == 2'(gi)) ? bus.rx_data
                                                            : r_word[8*gi +: 8];
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (bus.start) w_state_next = HDR0;
      HDR0:  if (w_hs) w_state_next = HDR1;
      HDR1:  if (w_hs) w_state_next = w_hdr_bad ? ERR : DATA;
      DATA:  if (w_hs && (r_byte_idx == 2'd3)) w_state_next = WRITE;
      WRITE: w_state_next = w_last_word ? DONE : DATA;
      DONE:  if (bus.start) w_state_next = HDR0;
      ERR:   if (bus.start) w_state_next = HDR0;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_n        <= '0;
      r_byte_idx <= '0;
      r_word_idx <= '0;
      r_word     <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        HDR0: if (w_hs) r_n[7:0] <= bus.rx_data;
        HDR1: begin
          if (w_hs) begin
            r_n[15:8]  <= bus.rx_data;
            r_byte_idx <= '0;
            r_word_idx <= '0;
          end
        end
        DATA: begin
          if (w_hs) begin
            r_word     <= w_word_next;
            r_byte_idx <= r_byte_idx + 2'd1;
            // Address and data are latched on the 4th byte so they are
            // presented in WRITE and then held until the next word.
            if (r_byte_idx == 2'd3) begin
              r_wdata <= w_word_next;
              r_waddr <= BASE_ADDR + 32'({r_word_idx, 2'b00});
            end
          end
        end
        WRITE: r_word_idx <= r_word_idx + 16'd1;
        default: ;
      endcase
    end
  end

  assign bus.rx_ready   = w_rx_ready;
  assign bus.imem_we    = (r_state == WRITE);
  assign bus.imem_waddr = r_waddr;
  assign bus.imem_wdata = r_wdata;
  assign bus.cpu_reset  = (r_state == DONE);
  assign bus.done       = (r_state == DONE);
  assign bus.error      = (r_state == ERR);
  assign bus.busy       = (r_state == HDR0) || (r_state == HDR1) ||
                          (r_state == DATA) || (r_state == WRITE);

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, instruction-memory capacity in 32-bit words (legal 1..65535).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first loaded word (word aligned).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a load.
REQ-006 SHALL have port rx_data  input  8  incoming program byte.
REQ-007 SHALL have port rx_valid  input  1  rx_data valid.
REQ-008 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port imem_we  output  1  instruction-memory write enable.
REQ-010 SHALL have port imem_waddr  output  32  instruction-memory byte write address.
REQ-011 SHALL have port imem_wdata  output  32  instruction word to write.
REQ-012 SHALL have port cpu_reset  output  1  active-low reset to the processor; low holds the core.
REQ-013 SHALL have port busy  output  1  load in progress.
REQ-014 SHALL have port done  output  1  program loaded; core released.
REQ-015 SHALL have port error  output  1  bad header; core held.

Function
REQ-016 SHALL accept a byte only on a cycle where rx_valid=1 and rx_ready=1 (handshake).
REQ-017 SHALL implement states IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR.
REQ-018 Stream format SHALL be: 16-bit word count N little-endian (low byte first), then 4N instruction bytes, each word little-endian (first byte -> bits [7:0], fourth -> [31:24]).
REQ-019 IDLE: rx_ready=0; start=1 -> HDR0.
REQ-020 HDR0: rx_ready=1; handshake captures N[7:0] -> HDR1.
REQ-021 HDR1: rx_ready=1; handshake captures N[15:8]; if N==0 or N>DEPTH -> ERR, else -> DATA with byte and word counters cleared.
REQ-022 DATA: rx_ready=1; each handshake stores the byte at lane byte_idx and increments byte_idx (2-bit, wraps 3->0); the 4th handshake -> WRITE.
REQ-023 WRITE: rx_ready=0, imem_we=1 for exactly one cycle, imem_waddr=BASE_ADDR+4*word_idx (32-bit modulo), imem_wdata=assembled word; then word_idx+1; if word_idx==N-1 -> DONE, else -> DATA.
REQ-024 imem_we SHALL assert in the cycle immediately following the 4th byte handshake of a word (latency 1); minimum 5 cycles per word.
REQ-025 DONE: done=1, cpu_reset=1, rx_ready=0; start=1 -> HDR0, done and cpu_reset go low next cycle.
REQ-026 ERR: error=1, cpu_reset=0, rx_ready=0, imem_we never asserted; start=1 -> HDR0, error cleared.
REQ-027 start SHALL be ignored in HDR0, HDR1, DATA and WRITE.
REQ-028 busy SHALL be 1 exactly in HDR0, HDR1, DATA, WRITE.
REQ-029 cpu_reset SHALL be 0 in every state except DONE.
REQ-030 All outputs SHALL be decoded from registered state/datapath only; no combinational path from any input to any output.
REQ-031 imem_waddr and imem_wdata SHALL hold their last values outside WRITE.

Reset
REQ-032 reset=0 SHALL force, asynchronously, state IDLE, all counters 0, rx_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, cpu_reset=0, busy=0, done=0, error=0.
REQ-033 reset asserted mid-load SHALL abandon the load; a partial word SHALL never be written; the next start SHALL begin a fresh header.

Verification
REQ-034 start; bytes 02 00 13 05 A0 00 93 05 B0 00 back-to-back -> writes (0x0, 0x00A00513), (0x4, 0x00B00593); then done=1, cpu_reset=1, busy=0.
REQ-035 start; header 00 00 -> error=1, cpu_reset=0, zero imem_we pulses; second start with valid stream -> error=0, load completes.
REQ-036 DEPTH=1024; header 01 04 (N=1025) -> ERR; header 00 04 (N=1024) with 4096 bytes -> 1024 writes, last at 0xFFC, done=1.
REQ-037 Same stream as REQ-034 with random rx_valid gaps (1-5 idle cycles) -> identical writes; rx_ready=0 on every WRITE cycle; no byte lost or duplicated.
REQ-038 reset pulsed low after 2 data bytes -> all outputs at REQ-032 values within the reset cycle, no write; subsequent full load -> correct words from BASE_ADDR.
REQ-039 start pulsed during DATA -> ignored, writes unchanged; start in DONE -> cpu_reset=0 next cycle, new load overwrites from BASE_ADDR.
